// File: rtl/stack_pkg.sv
// Shared types for the Forth data stack: opcodes, control states,
// opcode class masks and an operand-count helper.
package stack_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_PUSH = 3'd1,
        OP_POP  = 3'd2,
        OP_DUP  = 3'd3,
        OP_SWAP = 3'd4,
        OP_OVER = 3'd5,
        OP_PICK = 3'd6,
        OP_REPL = 3'd7
    } stk_op_e;

    typedef enum logic {
        IDLE    = 1'b0,
        PICK_RD = 1'b1
    } stk_st_e;

    // One bit per opcode, indexed by the stk_op_e value.
    // Push class: ops that grow the stack (overflow when full).
    localparam logic [7:0] OP_PUSH_CLASS = 8'b0010_1010;
    // Pop class: ops that consume operands (underflow when short).
    localparam logic [7:0] OP_POP_CLASS  = 8'b1011_1100;

    function automatic logic op_in(stk_op_e op, logic [7:0] mask);
        return mask[op];
    endfunction

    // Minimum depth an op needs to be legal.
    function automatic logic [1:0] op_need(stk_op_e op);
        if (!op_in(op, OP_POP_CLASS)) return 2'd0;
        return (op == OP_SWAP || op == OP_OVER) ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/stack_ram.sv
// Simple-dual-port RAM for the cells below NOS: one write port and one
// synchronous read port (read-before-write). Ports: clk, we_i/waddr_i/
// wdata_i write side, raddr_i read address, rdata_o registered data.
module stack_ram #(
    parameter int N  = 62,
    parameter int W  = 32,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [N];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/tos_stack.sv
// Forth data stack: TOS/NOS in registers, deeper cells in stack_ram.
// Ports: clk, rst (async low), en, valid/ready handshake, op, vi data,
// tos/nos outputs, depth/empty/full status, sticky err_* and err_clr.
module tos_stack
    import stack_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int DSZ   = 32,
    parameter int SSZ   = $clog2(DEPTH),
    parameter int DW    = $clog2(DEPTH) + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           valid,
    output logic           ready,
    input  stk_op_e        op,
    input  logic [DSZ-1:0] vi,
    output logic [DSZ-1:0] tos,
    output logic [DSZ-1:0] nos,
    output logic [DW-1:0]  depth,
    output logic           empty,
    output logic           full,
    output logic           err_ovf,
    output logic           err_unf,
    output logic           err_rng,
    input  logic           err_clr
);

    localparam logic [DW-1:0]  D_ONE = DW'(1);
    localparam logic [DW-1:0]  D_TWO = DW'(2);
    localparam logic [DW-1:0]  D_MAX = DW'(DEPTH);
    localparam logic [SSZ-1:0] S_ONE = SSZ'(1);

    logic [DSZ-1:0] tos_q, tos_d;
    logic [DSZ-1:0] nos_q, nos_d;
    logic [DW-1:0]  depth_q, depth_d;
    logic [SSZ-1:0] sp_q, sp_d;
    logic [SSZ-1:0] pick_addr_q, pick_addr_d;
    stk_st_e        st_q, st_d;
    logic           err_ovf_q, err_ovf_d;
    logic           err_unf_q, err_unf_d;
    logic           err_rng_q, err_rng_d;
    logic [DSZ-1:0] fwd_q;
    logic           fwd_hit_q, fwd_hit_d;

    logic           accept;
    logic           is_full;
    logic [SSZ-1:0] pick_n;
    logic           pick_go;
    logic           set_ovf, set_unf, set_rng;
    logic [DSZ-1:0] push_v;
    logic           ram_we;
    logic [SSZ-1:0] ram_raddr;
    logic [DSZ-1:0] ram_rdata;
    logic [DSZ-1:0] rd_data;

    assign ready   = (st_q == IDLE);
    assign accept  = valid & ready & en;
    assign is_full = (depth_q == D_MAX);
    assign pick_n  = vi[SSZ-1:0];
    // A write last cycle to the address being read returns stale RAM data.
    assign rd_data = fwd_hit_q ? fwd_q : ram_rdata;

    always_comb begin
        unique case (op)
            OP_DUP:  push_v = tos_q;
            OP_OVER: push_v = nos_q;
            default: push_v = vi;
        endcase
    end

    always_comb begin
        tos_d       = tos_q;
        nos_d       = nos_q;
        depth_d     = depth_q;
        sp_d        = sp_q;
        st_d        = st_q;
        pick_addr_d = pick_addr_q;
        set_ovf     = 1'b0;
        set_unf     = 1'b0;
        set_rng     = 1'b0;
        pick_go     = 1'b0;
        ram_we      = 1'b0;

        if (st_q == PICK_RD) begin
            if (en) begin
                tos_d = rd_data;
                st_d  = IDLE;
            end
        end else if (accept) begin
            if (depth_q < DW'(op_need(op))) begin
                set_unf = 1'b1;
            end else if (op_in(op, OP_PUSH_CLASS) && is_full) begin
                set_ovf = 1'b1;
            end else begin
                unique case (op)
                    OP_PUSH, OP_DUP, OP_OVER: begin
                        tos_d   = push_v;
                        nos_d   = tos_q;
                        depth_d = depth_q + D_ONE;
                        if (depth_q >= D_TWO) begin
                            ram_we = 1'b1;
                            sp_d   = sp_q + S_ONE;
                        end
                    end
                    OP_POP: begin
                        tos_d   = nos_q;
                        depth_d = depth_q - D_ONE;
                        if (depth_q > D_TWO) begin
                            nos_d = rd_data;
                            sp_d  = sp_q - S_ONE;
                        end else begin
                            nos_d = '0;
                        end
                    end
                    OP_SWAP: begin
                        tos_d = nos_q;
                        nos_d = tos_q;
                    end
                    OP_REPL: begin
                        tos_d = vi;
                    end
                    OP_PICK: begin
                        if (DW'(pick_n) >= depth_q) begin
                            set_rng = 1'b1;
                            tos_d   = '0;
                        end else if (pick_n == S_ONE) begin
                            tos_d = nos_q;
                        end else if (pick_n != '0) begin
                            // Element n sits at ram[sp-1-(n-2)].
                            pick_go     = 1'b1;
                            st_d        = PICK_RD;
                            pick_addr_d = sp_q + S_ONE - pick_n;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end

        err_ovf_d = (en & err_clr) ? 1'b0 : (err_ovf_q | set_ovf);
        err_unf_d = (en & err_clr) ? 1'b0 : (err_unf_q | set_unf);
        err_rng_d = (en & err_clr) ? 1'b0 : (err_rng_q | set_rng);
    end

    // Keep ram[sp-1] in the read register, except while a PICK is
    // in flight, where a stalled PICK_RD keeps re-reading its cell.
    always_comb begin
        if (pick_go) begin
            ram_raddr = pick_addr_d;
        end else if (st_q == PICK_RD && !en) begin
            ram_raddr = pick_addr_q;
        end else begin
            ram_raddr = sp_d - S_ONE;
        end
        fwd_hit_d = ram_we && (sp_q == ram_raddr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tos_q       <= '0;
            nos_q       <= '0;
            depth_q     <= '0;
            sp_q        <= '0;
            pick_addr_q <= '0;
            st_q        <= IDLE;
            err_ovf_q   <= 1'b0;
            err_unf_q   <= 1'b0;
            err_rng_q   <= 1'b0;
            fwd_q       <= '0;
            fwd_hit_q   <= 1'b0;
        end else begin
            tos_q       <= tos_d;
            nos_q       <= nos_d;
            depth_q     <= depth_d;
            sp_q        <= sp_d;
            pick_addr_q <= pick_addr_d;
            st_q        <= st_d;
            err_ovf_q   <= err_ovf_d;
            err_unf_q   <= err_unf_d;
            err_rng_q   <= err_rng_d;
            fwd_q       <= nos_q;
            fwd_hit_q   <= fwd_hit_d;
        end
    end

    stack_ram #(
        .N  (DEPTH - 2),
        .W  (DSZ),
        .AW (SSZ)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (sp_q),
        .wdata_i (nos_q),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    assign tos     = tos_q;
    assign nos     = nos_q;
    assign depth   = depth_q;
    assign empty   = (depth_q == '0);
    assign full    = is_full;
    assign err_ovf = err_ovf_q;
    assign err_unf = err_unf_q;
    assign err_rng = err_rng_q;

endmodule

// File: doc/tos_stack.md
Name: tos_stack

Overview:
- Parametrised Forth data stack, successor to the single-register EBR stack.
- TOS and NOS are held in registers; deeper cells are held in a simple-dual-port sync-read RAM.
- Supports the full primitive set (PUSH/POP/DUP/SWAP/OVER/PICK/REPL), depth/status outputs and sticky error flags.
- Sits between the eForth inner interpreter/ALU and block RAM; the ALU reads tos/nos directly with zero latency.

Parameters:
- DEPTH, 64, total element capacity including TOS and NOS; must be >= 4 and a power of 2.
- DSZ, 32, data width in bits.
- SSZ, $clog2(DEPTH), RAM address width and PICK index width.
- DW, $clog2(DEPTH)+1, width of the depth count.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  clock enable; when low, all state holds and ready still reflects busy.
- valid  in  1  request strobe; an op executes when valid & ready & en.
- ready  out  1  low only during the second cycle of PICK.
- op  in  3  stk_op_e: NOP, PUSH, POP, DUP, SWAP, OVER, PICK, REPL.
- vi  in  DSZ  PUSH/REPL data; vi[SSZ-1:0] is the PICK index.
- tos  out  DSZ  top of stack (0 when depth < 1).
- nos  out  DSZ  next on stack (0 when depth < 2).
- depth  out  DW  element count, 0..DEPTH.
- empty  out  1  depth == 0.
- full  out  1  depth == DEPTH.
- err_ovf  out  1  sticky overflow flag.
- err_unf  out  1  sticky underflow flag.
- err_rng  out  1  sticky PICK range error.
- err_clr  in  1  synchronous clear of all sticky error flags; the clear has priority over a same-cycle set.

Behaviour:
- Reset (rst low, async): tos = nos = 0, depth = 0, sp = 0, ready = 1, all err_* = 0, FSM in IDLE. RAM contents are don't-care.
- Storage layout:
  - Elements below NOS live at ram[0..sp-1], with sp = max(depth-2, 0).
  - ram[sp-1] must be available every cycle with no stall. The sync-read port is addressed by sp_next-1; a same-cycle write to that address is forwarded.
- Single-cycle ops (result visible the cycle after acceptance):
  - PUSH: illegal if full. Otherwise tos <= vi, nos <= tos, and if depth >= 2 then ram[sp] <= nos, sp++. depth++.
  - POP (also used as DROP): illegal if empty. tos <= nos; nos <= ram[sp-1] if depth > 2, else 0; sp-- if depth > 2. depth--.
  - DUP: illegal if empty or full. Same as PUSH with vi = tos.
  - OVER: needs depth >= 2 and not full. Same as PUSH with vi = nos.
  - SWAP: needs depth >= 2. Exchange tos and nos; depth unchanged.
  - REPL: needs depth >= 1. tos <= vi; depth unchanged.
  - NOP, or valid low: no state change.
- PICK n (n = vi[SSZ-1:0]):
  - n = 0: tos <= tos (single cycle). n = 1: tos <= nos (single cycle). Depth is unchanged in all cases.
  - n >= 2: FSM goes IDLE -> PICK_RD. In the accept cycle the RAM address is sp-1-(n-2). In PICK_RD, ready = 0 and tos <= RAM data; then return to IDLE. Latency is 2 cycles.
  - Range rule: n >= depth sets err_rng and tos <= 0, single cycle, no RAM access.
- Illegal op: no state change at all; set err_ovf (push class) or err_unf (pop/swap/over/repl class).
- Width rules:
  - depth is DW bits, so DEPTH is representable.
  - All sp arithmetic is modulo 2^SSZ but guarded by depth, so it never wraps in legal use.
- en low in PICK_RD: the FSM holds; the RAM read data is re-registered when en returns.
- Reset asserted mid-PICK: the FSM returns to IDLE immediately and ready = 1.

Decomposition:
- Package stack_pkg:
  - typedef enum logic [2:0] stk_op_e, replacing the global stack_ops.
  - typedef enum stk_st_e {IDLE, PICK_RD}.
  - Constants OP_PUSH_CLASS and OP_POP_CLASS (masks used for error classification).
- Sub-module stack_ram #(DEPTH-2, DSZ): 1 write port, 1 sync-read port, inferred (EBR on iCE40). Forwarding logic stays in tos_stack.

Test Plan:
- After reset: push 0x11, 0x22, 0x33 → tos=0x33, nos=0x22, depth=3. POP x3 → tos sequence 0x22, 0x11, 0; depth=0; empty=1.
- Fill to DEPTH with values 1..64, then PUSH 0x99 → err_ovf=1, depth=64, tos=64. Pop all 64 → values 64..1 in order. Next POP → err_unf=1.
- Stack 5,6,7: SWAP → tos=6, nos=7. OVER → tos=7, depth=4. DUP → tos=7, nos=7, depth=5.
- Stack 10,20,30,40: PICK 3 → ready low exactly one cycle, tos=10, depth=4. PICK 9 → err_rng=1, tos=0.
- PUSH then POP back-to-back at depth 2↔3 for 4 cycles → no stall; tos/nos correct every cycle, exercising the forwarding path.
- Assert rst during PICK_RD → ready=1, depth=0, err_*=0 on the same cycle. err_clr together with an overflowing PUSH → err_ovf stays 0.
